// File: rtl/pixel_array_ctrl.sv
// pixel_array_ctrl: frame sequencer for a W x H pixel array (erase, expose, ramp conversion, row readout).
// Ports: clk/reset (async, active-high); START/ABORT frame control; BUSY status;
//        PIX_RESET/ERASE/EXPOSE/RAMP pixel controls; READBUS one-hot row select;
//        DATA_OE/DATA_OUT conversion count onto the column bus; DATA_IN bus readback;
//        ROW_DATA/ROW_IDX/ROW_VALID/ROW_READY row handshake; FRAME_DONE end-of-frame pulse.
module pixel_array_ctrl #(
    parameter int W         = 4,
    parameter int H         = 4,
    parameter int C_ERASE   = 5,
    parameter int C_EXPOSE  = 255,
    parameter int C_CONVERT = 255,
    parameter int C_SETTLE  = 2,
    localparam int RW       = (H > 1) ? $clog2(H) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            START,
    input  logic            ABORT,
    output logic            BUSY,
    output logic            PIX_RESET,
    output logic            ERASE,
    output logic            EXPOSE,
    output logic            RAMP,
    output logic [H-1:0]    READBUS,
    output logic            DATA_OE,
    output logic [W*8-1:0]  DATA_OUT,
    input  logic [W*8-1:0]  DATA_IN,
    output logic [W*8-1:0]  ROW_DATA,
    output logic [RW-1:0]   ROW_IDX,
    output logic            ROW_VALID,
    input  logic            ROW_READY,
    output logic            FRAME_DONE
);
    localparam int MX1 = (C_EXPOSE > C_ERASE) ? C_EXPOSE : C_ERASE;
    localparam int MX2 = (MX1 > C_SETTLE) ? MX1 : C_SETTLE;
    localparam int CW  = $clog2((MX2 > 256) ? MX2 : 256);
    localparam logic [CW-1:0] LAST_ERASE  = CW'(C_ERASE - 1);
    localparam logic [CW-1:0] LAST_EXPOSE = CW'(C_EXPOSE - 1);
    localparam logic [CW-1:0] LAST_SETTLE = CW'(C_SETTLE - 1);
    localparam logic [7:0]    LAST_CONV   = 8'(C_CONVERT);
    localparam logic [RW-1:0] LAST_ROW    = RW'(H - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_SETTLE, S_PRESENT, S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    conv;
    logic [RW-1:0] row;

    // Every output is registered alongside the state transition that selects it,
    // so each output reflects the state being entered at the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            conv       <= '0;
            row        <= '0;
            BUSY       <= 1'b0;
            PIX_RESET  <= 1'b0;
            ERASE      <= 1'b0;
            EXPOSE     <= 1'b0;
            RAMP       <= 1'b0;
            READBUS    <= '0;
            DATA_OE    <= 1'b0;
            DATA_OUT   <= '0;
            ROW_DATA   <= '0;
            ROW_IDX    <= '0;
            ROW_VALID  <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            PIX_RESET  <= 1'b0;
            ERASE      <= 1'b0;
            EXPOSE     <= 1'b0;
            RAMP       <= 1'b0;
            DATA_OE    <= 1'b0;
            DATA_OUT   <= '0;
            FRAME_DONE <= 1'b0;
            BUSY       <= 1'b1;
            if (ABORT && state != S_IDLE) begin
                state     <= S_IDLE;
                BUSY      <= 1'b0;
                READBUS   <= '0;
                ROW_VALID <= 1'b0;
                ROW_DATA  <= '0;
                ROW_IDX   <= '0;
                cnt       <= '0;
                conv      <= '0;
                row       <= '0;
            end else begin
                case (state)
                    S_IDLE:
                        if (START && !ABORT) begin
                            state     <= S_ERASE;
                            PIX_RESET <= 1'b1;
                            ERASE     <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            BUSY <= 1'b0;
                        end
                    S_ERASE:
                        if (cnt == LAST_ERASE) begin
                            state  <= S_EXPOSE;
                            EXPOSE <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            PIX_RESET <= 1'b1;
                            ERASE     <= 1'b1;
                            cnt       <= cnt + 1'b1;
                        end
                    S_EXPOSE:
                        if (cnt == LAST_EXPOSE) begin
                            state   <= S_CONVERT;
                            RAMP    <= 1'b1;
                            DATA_OE <= 1'b1;
                            conv    <= '0;
                            cnt     <= '0;
                        end else begin
                            EXPOSE <= 1'b1;
                            cnt    <= cnt + 1'b1;
                        end
                    S_CONVERT:
                        if (conv == LAST_CONV) begin
                            state   <= S_SETTLE;
                            READBUS <= H'(1);
                            row     <= '0;
                            cnt     <= '0;
                            conv    <= '0;
                        end else begin
                            RAMP     <= 1'b1;
                            DATA_OE  <= 1'b1;
                            conv     <= conv + 8'd1;
                            DATA_OUT <= {W{conv + 8'd1}};
                        end
                    S_SETTLE:
                        if (cnt == LAST_SETTLE) begin
                            state     <= S_PRESENT;
                            ROW_DATA  <= DATA_IN;
                            ROW_IDX   <= row;
                            ROW_VALID <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    S_PRESENT:
                        if (ROW_READY) begin
                            ROW_VALID <= 1'b0;
                            if (row == LAST_ROW) begin
                                state      <= S_DONE;
                                FRAME_DONE <= 1'b1;
                                READBUS    <= '0;
                                ROW_DATA   <= '0;
                                ROW_IDX    <= '0;
                                row        <= '0;
                            end else begin
                                state   <= S_SETTLE;
                                row     <= row + 1'b1;
                                READBUS <= READBUS << 1;
                            end
                        end
                    S_DONE: begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pixel_array_ctrl.sv
// tb_pixel_array_ctrl: self-checking bench for pixel_array_ctrl (directed table, corner sequences, random vs model).
// Ports: none (top-level bench); drives a default-size instance and a small W=2/H=1 instance.
module tb_pixel_array_ctrl;
    localparam int W = 4, H = 4, CE = 5, CX = 255, CC = 255, CS = 2;

    typedef struct packed {
        logic busy, pixr, era, exps, ramp, oe, valid, done;
        logic [3:0]  rb;
        logic [1:0]  idx;
        logic [31:0] dout;
        logic [31:0] rdata;
    } obs_t;

    typedef struct {
        logic        start, abort, ready;
        logic [31:0] din;
        int          adv;
        obs_t        exp;
    } vec_t;

    localparam logic [7:0] K_E = 8'b1110_0000, K_X = 8'b1001_0000, K_C = 8'b1000_1100;
    localparam logic [7:0] K_S = 8'b1000_0000, K_P = 8'b1000_0010, K_D = 8'b1000_0001, K_I = 8'b0;

    logic clk = 1'b0, reset = 1'b1;
    logic start, abort, ready;
    logic [31:0] din;
    logic busy, pix_reset, erase_o, expose_o, ramp, data_oe, row_valid, frame_done;
    logic [3:0]  readbus;
    logic [31:0] data_out, row_data;
    logic [1:0]  row_idx;

    logic s_start, s_abort, s_ready;
    logic [15:0] s_din, s_dout, s_rdata;
    logic s_busy, s_pixr, s_erase, s_expose, s_ramp, s_oe, s_valid, s_done;
    logic [0:0] s_readbus, s_idx;

    int n_chk = 0, n_fail = 0;
    int m_mode, m_t, m_row, m_rt;
    logic [31:0] m_data;
    logic [1:0]  m_idx;
    vec_t tv[23];

    always #5 clk = ~clk;

    pixel_array_ctrl #(.W(W), .H(H), .C_ERASE(CE), .C_EXPOSE(CX), .C_CONVERT(CC), .C_SETTLE(CS)) dut (
        .clk(clk), .reset(reset), .START(start), .ABORT(abort), .BUSY(busy),
        .PIX_RESET(pix_reset), .ERASE(erase_o), .EXPOSE(expose_o), .RAMP(ramp),
        .READBUS(readbus), .DATA_OE(data_oe), .DATA_OUT(data_out), .DATA_IN(din),
        .ROW_DATA(row_data), .ROW_IDX(row_idx), .ROW_VALID(row_valid),
        .ROW_READY(ready), .FRAME_DONE(frame_done)
    );

    pixel_array_ctrl #(.W(2), .H(1), .C_ERASE(1), .C_EXPOSE(1), .C_CONVERT(3), .C_SETTLE(1)) dut_s (
        .clk(clk), .reset(reset), .START(s_start), .ABORT(s_abort), .BUSY(s_busy),
        .PIX_RESET(s_pixr), .ERASE(s_erase), .EXPOSE(s_expose), .RAMP(s_ramp),
        .READBUS(s_readbus), .DATA_OE(s_oe), .DATA_OUT(s_dout), .DATA_IN(s_din),
        .ROW_DATA(s_rdata), .ROW_IDX(s_idx), .ROW_VALID(s_valid),
        .ROW_READY(s_ready), .FRAME_DONE(s_done)
    );

    function automatic obs_t cur();
        return {busy, pix_reset, erase_o, expose_o, ramp, data_oe, row_valid, frame_done,
                readbus, row_idx, data_out, row_data};
    endfunction

    function automatic logic [41:0] sobs();
        return {s_busy, s_pixr, s_erase, s_expose, s_ramp, s_oe, s_valid, s_done,
                s_readbus, s_idx, s_dout, s_rdata};
    endfunction

    function automatic obs_t mk(logic [7:0] c, logic [3:0] rb, logic [1:0] ix, logic [31:0] d, logic [31:0] r);
        return {c, rb, ix, d, r};
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: frame position as elapsed time for the fixed phases,
    // then row number plus cycles spent on that row for the readout.
    function automatic obs_t model_obs();
        obs_t o = '0;
        o.rdata = m_data;
        o.idx   = m_idx;
        if (m_mode == 1) begin
            o.busy = 1'b1;
            if (m_t < CE) begin
                o.pixr = 1'b1;
                o.era  = 1'b1;
            end else if (m_t < CE + CX) begin
                o.exps = 1'b1;
            end else begin
                o.ramp = 1'b1;
                o.oe   = 1'b1;
                o.dout = {4{8'(m_t - CE - CX)}};
            end
        end else if (m_mode == 2) begin
            o.busy  = 1'b1;
            o.rb    = 4'(1 << m_row);
            o.valid = (m_rt == CS);
        end else if (m_mode == 3) begin
            o.busy = 1'b1;
            o.done = 1'b1;
        end
        return o;
    endfunction

    task automatic model_step(input logic s, input logic a, input logic r, input logic [31:0] d);
        if (m_mode != 0 && a) begin
            m_mode = 0;
            m_data = '0;
            m_idx  = '0;
        end else if (m_mode == 0) begin
            if (s && !a) begin
                m_mode = 1;
                m_t    = 0;
            end
        end else if (m_mode == 1) begin
            m_t++;
            if (m_t == CE + CX + CC + 1) begin
                m_mode = 2;
                m_row  = 0;
                m_rt   = 0;
            end
        end else if (m_mode == 2) begin
            if (m_rt < CS) begin
                m_rt++;
                if (m_rt == CS) begin
                    m_data = d;
                    m_idx  = 2'(m_row);
                end
            end else if (r) begin
                if (m_row == H - 1) begin
                    m_mode = 3;
                    m_data = '0;
                    m_idx  = '0;
                end else begin
                    m_row++;
                    m_rt = 0;
                end
            end
        end else begin
            m_mode = 0;
        end
    endtask

    initial begin
        int n, fd;
        tv[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1,    mk(K_E, 4'h0, 2'd0, 32'h0, 32'h0)};
        tv[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        4,    mk(K_E, 4'h0, 2'd0, 32'h0, 32'h0)};
        tv[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1,    mk(K_X, 4'h0, 2'd0, 32'h0, 32'h0)};
        tv[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        254,  mk(K_X, 4'h0, 2'd0, 32'h0, 32'h0)};
        tv[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1,    mk(K_C, 4'h0, 2'd0, 32'h0, 32'h0)};
        tv[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        8'h40, mk(K_C, 4'h0, 2'd0, 32'h40404040, 32'h0)};
        tv[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        8'hBF, mk(K_C, 4'h0, 2'd0, 32'hFFFFFFFF, 32'h0)};
        tv[7]  = '{1'b0, 1'b0, 1'b0, 32'h11111111, 1,    mk(K_S, 4'h1, 2'd0, 32'h0, 32'h0)};
        tv[8]  = '{1'b0, 1'b0, 1'b0, 32'h11111111, 2,    mk(K_P, 4'h1, 2'd0, 32'h0, 32'h11111111)};
        tv[9]  = '{1'b0, 1'b0, 1'b0, 32'h99999999, 5,    mk(K_P, 4'h1, 2'd0, 32'h0, 32'h11111111)};
        tv[10] = '{1'b0, 1'b0, 1'b1, 32'h22222222, 1,    mk(K_S, 4'h2, 2'd0, 32'h0, 32'h11111111)};
        tv[11] = '{1'b0, 1'b0, 1'b0, 32'h22222222, 2,    mk(K_P, 4'h2, 2'd1, 32'h0, 32'h22222222)};
        tv[12] = '{1'b0, 1'b0, 1'b0, 32'h22222222, 10,   mk(K_P, 4'h2, 2'd1, 32'h0, 32'h22222222)};
        tv[13] = '{1'b0, 1'b0, 1'b1, 32'hDDCCBBAA, 1,    mk(K_S, 4'h4, 2'd1, 32'h0, 32'h22222222)};
        tv[14] = '{1'b0, 1'b0, 1'b0, 32'hDDCCBBAA, 2,    mk(K_P, 4'h4, 2'd2, 32'h0, 32'hDDCCBBAA)};
        tv[15] = '{1'b0, 1'b0, 1'b0, 32'h0,        10,   mk(K_P, 4'h4, 2'd2, 32'h0, 32'hDDCCBBAA)};
        tv[16] = '{1'b0, 1'b0, 1'b1, 32'h44444444, 3,    mk(K_P, 4'h8, 2'd3, 32'h0, 32'h44444444)};
        tv[17] = '{1'b1, 1'b0, 1'b1, 32'h0,        1,    mk(K_D, 4'h0, 2'd0, 32'h0, 32'h0)};
        tv[18] = '{1'b1, 1'b0, 1'b1, 32'h0,        1,    mk(K_I, 4'h0, 2'd0, 32'h0, 32'h0)};
        tv[19] = '{1'b1, 1'b0, 1'b1, 32'h0,        1,    mk(K_E, 4'h0, 2'd0, 32'h0, 32'h0)};
        tv[20] = '{1'b0, 1'b1, 1'b1, 32'h0,        1,    mk(K_I, 4'h0, 2'd0, 32'h0, 32'h0)};
        tv[21] = '{1'b1, 1'b1, 1'b1, 32'h0,        1,    mk(K_I, 4'h0, 2'd0, 32'h0, 32'h0)};
        tv[22] = '{1'b0, 1'b0, 1'b0, 32'h0,        3,    mk(K_I, 4'h0, 2'd0, 32'h0, 32'h0)};

        start = 0; abort = 0; ready = 0; din = '0;
        s_start = 0; s_abort = 0; s_ready = 1; s_din = 16'hBEEF;
        reset = 1;
        repeat (2) @(negedge clk);
        chk("reset_main", cur(), '0);
        chk("reset_small", sobs(), '0);
        reset = 0;

        for (int i = 0; i < 23; i++) begin
            start = tv[i].start; abort = tv[i].abort; ready = tv[i].ready; din = tv[i].din;
            repeat (tv[i].adv) @(negedge clk);
            chk($sformatf("vec%0d", i), cur(), tv[i].exp);
        end

        start = 1; @(negedge clk); start = 0;
        repeat (324) @(negedge clk);
        chk("convert_0x40", cur(), mk(K_C, 4'h0, 2'd0, 32'h40404040, 32'h0));
        abort = 1; @(negedge clk); abort = 0;
        chk("abort_convert", cur(), '0);
        fd = 0;
        repeat (5) begin @(negedge clk); fd += int'(frame_done); end
        chk("no_done_after_abort", fd, 0);
        ready = 1; start = 1; @(negedge clk); start = 0;
        n = 1;
        while (!frame_done && n < 700) begin @(negedge clk); n++; end
        chk("frame_length", n, 529);
        @(negedge clk);
        chk("done_one_pulse", cur(), '0);

        din = 32'h5A5A5A5A; ready = 0; start = 1;
        @(negedge clk);
        repeat (9) @(negedge clk);
        chk("start_ignored_busy", cur(), mk(K_X, 4'h0, 2'd0, 32'h0, 32'h0));
        repeat (509) @(negedge clk);
        chk("present_row0", cur(), mk(K_P, 4'h1, 2'd0, 32'h0, 32'h5A5A5A5A));
        start = 0;
        #2 reset = 1;
        #1 chk("async_reset", cur(), '0);
        @(negedge clk); reset = 0;

        s_start = 1; @(negedge clk); s_start = 0;
        chk("small_erase", sobs(), {8'b1110_0000, 2'b00, 32'h0});
        @(negedge clk);
        chk("small_expose", sobs(), {8'b1001_0000, 2'b00, 32'h0});
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("small_conv%0d", k), sobs(), {8'b1000_1100, 2'b00, {2{8'(k)}}, 16'h0});
            @(negedge clk);
        end
        chk("small_settle", sobs(), {8'b1000_0000, 1'b1, 1'b0, 32'h0});
        @(negedge clk);
        chk("small_present", sobs(), {8'b1000_0010, 1'b1, 1'b0, 16'h0, 16'hBEEF});
        @(negedge clk);
        chk("small_done", sobs(), {8'b1000_0001, 2'b00, 32'h0});
        @(negedge clk);
        chk("small_idle", sobs(), '0);

        reset = 1; @(negedge clk); reset = 0;
        start = 0; abort = 0; ready = 0; din = '0;
        m_mode = 0; m_t = 0; m_row = 0; m_rt = 0; m_data = '0; m_idx = '0;
        repeat (6000) begin
            @(negedge clk);
            chk("random", cur(), model_obs());
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 1499) == 0);
            ready = 1'($urandom_range(0, 1));
            din   = $urandom;
            model_step(start, abort, ready, din);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pixel_array_ctrl.md
Name: pixel_array_ctrl

Overview:
- Sequencer for the W×H pixel array. Runs one frame per START: erase, expose, ramp conversion, then row-by-row readout.
- During conversion it drives the shared 8-bit-per-column data bus with the conversion count.
- During readout it selects one row at a time and delivers each captured row over a valid/ready handshake.
- Sits between the array and the downstream frame/readout logic.

Parameters:
- W, 4, columns (bus width W*8).
- H, 4, rows (READBUS width).
- C_ERASE, 5, cycles ERASE and PIX_RESET are held (≥1).
- C_EXPOSE, 255, cycles EXPOSE is held (≥1).
- C_CONVERT, 255, final conversion count value (1..255).
- C_SETTLE, 2, cycles a row is selected before capture (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high controller reset.
- START  in  1  frame request, sampled in IDLE only.
- ABORT  in  1  synchronous abort to IDLE.
- BUSY  out  1  high in every state except IDLE.
- PIX_RESET  out  1  pixel RESET line.
- ERASE  out  1  pixel ERASE line.
- EXPOSE  out  1  pixel EXPOSE line.
- RAMP  out  1  ramp enable.
- READBUS  out  H  one-hot row select.
- DATA_OE  out  1  enable for the bus driver (external tristate).
- DATA_OUT  out  W*8  conversion count, replicated on every column byte.
- DATA_IN  in  W*8  bus value read back from the array.
- ROW_DATA  out  W*8  captured row.
- ROW_IDX  out  clog2(H) (min 1)  index of ROW_DATA.
- ROW_VALID  out  1  ROW_DATA valid.
- ROW_READY  in  1  downstream accept.
- FRAME_DONE  out  1  one-cycle pulse after the last row is accepted.

Behaviour:
- Reset (async, active-high): state IDLE. Every output is 0, including ROW_DATA, ROW_IDX and DATA_OUT. Internal counters are 0.
- All outputs are registered; each is a function of the current state.
- IDLE: START=1 at an edge enters ERASE at that edge.
- ERASE: PIX_RESET=1 and ERASE=1 for exactly C_ERASE cycles, then EXPOSE.
- EXPOSE: EXPOSE=1 for exactly C_EXPOSE cycles, then CONVERT.
- CONVERT:
  - RAMP=1, DATA_OE=1.
  - The 8-bit count starts at 0 and increments by 1 each cycle.
  - DATA_OUT = {W{count}}.
  - After the cycle with count == C_CONVERT, go to SETTLE with row=0. Duration is C_CONVERT+1 cycles.
  - DATA_OE and RAMP are 0 in every other state. DATA_OE=1 and any READBUS bit are never high in the same cycle.
- SETTLE:
  - READBUS = 1<<row for C_SETTLE cycles.
  - On the last settle edge: ROW_DATA<=DATA_IN, ROW_IDX<=row, ROW_VALID<=1, and go to PRESENT.
- PRESENT:
  - READBUS stays 1<<row. ROW_VALID=1. ROW_DATA and ROW_IDX are stable.
  - Handshake: ROW_VALID & ROW_READY at an edge.
    - row<H-1: go to SETTLE with row+1, ROW_VALID<=0.
    - row==H-1: go to DONE.
  - ROW_READY may be held high permanently; every row still spends C_SETTLE+1 cycles minimum.
- DONE: FRAME_DONE=1 for one cycle, all row/bus outputs 0, then IDLE. BUSY=1 during DONE.
- ABORT=1 in any non-IDLE state: next state IDLE with all outputs 0 and no FRAME_DONE. ABORT takes priority over the handshake.
- START outside IDLE is ignored. START and ABORT together in IDLE: ABORT wins and the state stays IDLE.
- START held high continuously: a new frame starts on the first cycle back in IDLE after DONE.
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0. No partial FRAME_DONE.

Test Plan:
- Basic frame, defaults, ROW_READY=1: START pulse gives ERASE=PIX_RESET=1 for 5 cycles, then EXPOSE=1 for 255, then RAMP=1 with DATA_OUT 0x00..0xFF over 256 cycles. READBUS then steps 0001, 0010, 0100, 1000, each row 3 cycles, ROW_IDX 0..3. FRAME_DONE pulses once. Total 5+255+256+12+1 cycles.
- Capture check: DATA_IN driven 0xDDCCBBAA while READBUS=0100 → ROW_DATA=0xDDCCBBAA with ROW_IDX=2. Data stays stable while ROW_READY=0 for 10 cycles.
- Backpressure: ROW_READY held 0 on row 1 → state stays PRESENT and READBUS=0010 holds. ROW_READY=1 for one cycle → advance to row 2.
- ABORT mid-CONVERT (count=0x40) → next cycle all outputs 0 and BUSY=0, no FRAME_DONE. A fresh START gives a full frame again.
- Async reset asserted between edges during PRESENT → outputs 0 immediately without waiting for a clock edge. START while BUSY is ignored (no restart of ERASE).
- Small params W=2, H=1, C_CONVERT=3, C_SETTLE=1: DATA_OUT 0x0000, 0x0101, 0x0202, 0x0303 → single row, then FRAME_DONE.
